// File: rtl/bingo_master_gen.sv
// Master-side controller for a two-player N x N bingo game: board entry, turn-taking
// over the interboard link, circle tracking, line counting and an optional guess timeout.
module bingo_master_gen #(
  parameter int N            = 5,
  parameter int NW           = 5,
  parameter int LINES_TO_WIN = 5,
  parameter int TIMEOUT      = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        interboard_rst,
  input  logic                        start_game,
  input  logic                        enter_pulse,
  input  logic [NW-1:0]               cur_number,
  input  logic                        inter_ready,
  input  logic                        interboard_en,
  input  logic [2:0]                  interboard_msg_type,
  input  logic [NW-1:0]               interboard_number,
  output logic                        my_turn,
  output logic                        transmit,
  output logic                        ctrl_en,
  output logic [2:0]                  ctrl_msg_type,
  output logic [NW-1:0]               ctrl_number,
  output logic [NW*N*N-1:0]           map,
  output logic [N*N-1:0]              circle,
  output logic [$clog2(2*N+3)-1:0]    line_count,
  output logic                        timeout_flag,
  output logic [3:0]                  o_dbg_state
);

  localparam int NN  = N * N;
  localparam int LW  = $clog2(2 * N + 3);
  localparam int PW  = $clog2(NN);
  localparam int IW  = $clog2(NN + 1);
  localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TW1 = TW + 1;
  localparam logic [NN-1:0] ONE = NN'(1);

  localparam logic [2:0] MSG_STATE_TURN = 3'd1;
  localparam logic [2:0] MSG_SEL_NUM    = 3'd2;
  localparam logic [2:0] MSG_STATE_WIN  = 3'd3;

  typedef enum logic [3:0] {
    IDLE          = 4'd0,
    SEND_START    = 4'd1,
    SEL           = 4'd2,
    SEND_SEL_DONE = 4'd3,
    WAIT_P2_SEL   = 4'd4,
    GUESS         = 4'd5,
    CHECK_WIN     = 4'd6,
    SEND_NUM      = 4'd7,
    SEND_WIN      = 4'd8,
    WAIT_P2_GUESS = 4'd9,
    UPDATE        = 4'd10,
    FIN           = 4'd11
  } state_t;

  // Handshake: a SEND_* state holds transmit=1 with its message on ctrl_msg_type/ctrl_number
  // until inter_ready is high at a clock edge; ctrl_en marks only the first cycle of that state.
  // Incoming messages are single-cycle: interboard_en qualifies type and number for that cycle.

  state_t            r_state, w_next;
  logic [NW*NN-1:0]  r_map;
  logic [NN-1:0]     r_circle, r_used;
  logic [PW-1:0]     r_pos [NN];
  logic [IW-1:0]     r_idx;
  logic [NW-1:0]     r_guess_num, r_rx_num;
  logic [TW-1:0]     r_tmo_cnt;
  logic              r_ctrl_en, r_timeout_flag;

  logic              w_cur_in_range, w_rx_in_range, w_rx_ok, w_full;
  logic [PW-1:0]     w_cur_pidx, w_cur_pos, w_rx_pidx, w_rx_pos, w_auto_pos;
  logic [NN-1:0]     w_circle_upd;
  logic [LW-1:0]     w_upd_lines;
  logic              w_won, w_upd_won, w_tmo_hit, w_auto_found;
  logic [NW-1:0]     w_auto_num;
  logic              w_sel_acc, w_guess_acc, w_auto, w_rx_latch;
  logic              w_send_entry, w_enter_idle;

  function automatic logic [LW-1:0] count_lines(input logic [NN-1:0] c);
    logic [LW-1:0] n;
    logic row_f, col_f, d0, d1;
    n  = '0;
    d0 = 1'b1;
    d1 = 1'b1;
    for (int i = 0; i < N; i++) begin
      row_f = 1'b1;
      col_f = 1'b1;
      for (int j = 0; j < N; j++) begin
        row_f &= c[PW'(i * N + j)];
        col_f &= c[PW'(j * N + i)];
      end
      n  = n + LW'(row_f) + LW'(col_f);
      d0 &= c[PW'(i * N + i)];
      d1 &= c[PW'(i * N + (N - 1 - i))];
    end
    n = n + LW'(d0) + LW'(d1);
    return n;
  endfunction

  assign w_cur_in_range = (cur_number != '0) && (cur_number <= NW'(NN));
  assign w_cur_pidx     = PW'(cur_number - 1'b1);
  assign w_cur_pos      = r_pos[w_cur_pidx];
  assign w_full         = (r_idx == IW'(NN));

  assign w_rx_in_range  = (r_rx_num != '0) && (r_rx_num <= NW'(NN));
  assign w_rx_pidx      = PW'(r_rx_num - 1'b1);
  assign w_rx_pos       = r_pos[w_rx_pidx];
  assign w_rx_ok        = w_rx_in_range && r_used[w_rx_pidx] && !r_circle[w_rx_pos];
  assign w_circle_upd   = r_circle | (w_rx_ok ? (ONE << w_rx_pos) : '0);

  // UPDATE decides on the board including the cell it is about to circle.
  assign line_count     = count_lines(r_circle);
  assign w_upd_lines    = count_lines(w_circle_upd);
  assign w_won          = (line_count >= LW'(LINES_TO_WIN));
  assign w_upd_won      = (w_upd_lines >= LW'(LINES_TO_WIN));

  assign w_tmo_hit      = (TIMEOUT > 0) && (({1'b0, r_tmo_cnt} + 1'b1) == TW1'(TIMEOUT));

  always_comb begin
    w_auto_found = 1'b0;
    w_auto_num   = '0;
    w_auto_pos   = '0;
    for (int v = NN; v >= 1; v--) begin
      if (r_used[PW'(v - 1)] && !r_circle[r_pos[PW'(v - 1)]]) begin
        w_auto_found = 1'b1;
        w_auto_num   = NW'(v);
        w_auto_pos   = r_pos[PW'(v - 1)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_state <= IDLE;
    else if (interboard_rst) r_state <= IDLE;
    else                     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_sel_acc   = 1'b0;
    w_guess_acc = 1'b0;
    w_auto      = 1'b0;
    w_rx_latch  = 1'b0;
    case (r_state)
      IDLE:          if (start_game) w_next = SEND_START;
      SEND_START:    if (inter_ready) w_next = SEL;
      SEL: begin
        if (w_full) w_next = SEND_SEL_DONE;
        else if (enter_pulse && w_cur_in_range && !r_used[w_cur_pidx]) w_sel_acc = 1'b1;
      end
      SEND_SEL_DONE: if (inter_ready) w_next = WAIT_P2_SEL;
      WAIT_P2_SEL:
        if (interboard_en && interboard_msg_type == MSG_STATE_TURN) w_next = GUESS;
      GUESS: begin
        if (enter_pulse && w_cur_in_range && r_used[w_cur_pidx] && !r_circle[w_cur_pos]) begin
          w_guess_acc = 1'b1;
          w_next      = CHECK_WIN;
        end else if (w_tmo_hit && w_auto_found) begin
          w_auto = 1'b1;
          w_next = CHECK_WIN;
        end
      end
      CHECK_WIN:     w_next = w_won ? SEND_WIN : SEND_NUM;
      SEND_NUM:      if (inter_ready) w_next = WAIT_P2_GUESS;
      WAIT_P2_GUESS: begin
        if (interboard_en && interboard_msg_type == MSG_STATE_WIN) begin
          w_next = FIN;
        end else if (interboard_en && interboard_msg_type == MSG_SEL_NUM) begin
          w_rx_latch = 1'b1;
          w_next     = UPDATE;
        end
      end
      UPDATE:        w_next = w_upd_won ? SEND_WIN : GUESS;
      SEND_WIN:      if (inter_ready) w_next = FIN;
      FIN:           if (start_game) w_next = IDLE;
      default:       w_next = IDLE;
    endcase
  end

  assign w_send_entry = (w_next != r_state) &&
                        (w_next inside {SEND_START, SEND_SEL_DONE, SEND_NUM, SEND_WIN});
  assign w_enter_idle = (w_next == IDLE) && (r_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_map          <= '0;
      r_circle       <= '0;
      r_used         <= '0;
      r_idx          <= '0;
      r_guess_num    <= '0;
      r_rx_num       <= '0;
      r_tmo_cnt      <= '0;
      r_ctrl_en      <= 1'b0;
      r_timeout_flag <= 1'b0;
      for (int i = 0; i < NN; i++) r_pos[i] <= '0;
    end else if (interboard_rst || w_enter_idle) begin
      r_map          <= '0;
      r_circle       <= '0;
      r_used         <= '0;
      r_idx          <= '0;
      r_guess_num    <= '0;
      r_rx_num       <= '0;
      r_tmo_cnt      <= '0;
      r_ctrl_en      <= 1'b0;
      r_timeout_flag <= 1'b0;
    end else begin
      r_ctrl_en      <= w_send_entry;
      r_timeout_flag <= w_auto;
      if (w_sel_acc) begin
        r_map[NW*r_idx +: NW] <= cur_number;
        r_used[w_cur_pidx]    <= 1'b1;
        r_pos[w_cur_pidx]     <= PW'(r_idx);
        r_idx                 <= r_idx + 1'b1;
      end
      if (w_guess_acc) begin
        r_guess_num         <= cur_number;
        r_circle[w_cur_pos] <= 1'b1;
      end else if (w_auto) begin
        r_guess_num          <= w_auto_num;
        r_circle[w_auto_pos] <= 1'b1;
      end
      if (w_rx_latch) r_rx_num <= interboard_number;
      if (r_state == UPDATE) r_circle <= w_circle_upd;
      // Counter restarts whenever GUESS is (re)entered and freezes at the firing point.
      if (r_state != GUESS || TIMEOUT == 0) r_tmo_cnt <= '0;
      else if (!w_tmo_hit)                  r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  always_comb begin
    my_turn       = 1'b0;
    transmit      = 1'b0;
    ctrl_msg_type = '0;
    ctrl_number   = '0;
    case (r_state)
      SEL, GUESS, CHECK_WIN, FIN: my_turn = 1'b1;
      SEND_START, SEND_SEL_DONE: begin
        transmit      = 1'b1;
        ctrl_msg_type = MSG_STATE_TURN;
      end
      SEND_NUM: begin
        transmit      = 1'b1;
        ctrl_msg_type = MSG_SEL_NUM;
        ctrl_number   = r_guess_num;
      end
      SEND_WIN: begin
        transmit      = 1'b1;
        ctrl_msg_type = MSG_STATE_WIN;
      end
      default: ;
    endcase
  end

  assign ctrl_en      = r_ctrl_en;
  assign timeout_flag = r_timeout_flag;
  assign map          = r_map;
  assign circle       = r_circle;
  assign o_dbg_state  = r_state;

endmodule

// File: doc/bingo_master_gen.md
BINGO_MASTER_GEN -- requirements
Module: bingo_master_gen

Interface
REQ-001 SHALL have parameter N, default 5, meaning board side (3..8); board holds N*N cells with numbers 1..N*N.
REQ-002 SHALL have parameter NW, default 5, meaning number width; NW >= clog2(N*N+1).
REQ-003 SHALL have parameter LINES_TO_WIN, default 5, meaning completed lines (rows, columns, 2 diagonals) needed to win.
REQ-004 SHALL have parameter TIMEOUT, default 0, meaning guess-turn timeout in cycles; 0 disables it.
REQ-005 SHALL have ports clk (in, 1, the only clock) and rst_n (in, 1, asynchronous active-low reset).
REQ-006 SHALL have port interboard_rst (in, 1), a synchronous clear with the same effect as reset.
REQ-007 SHALL have ports start_game (in, 1), enter_pulse (in, 1, one-cycle strobe) and cur_number (in, NW, binary).
REQ-008 SHALL have ports inter_ready (in, 1), interboard_en (in, 1), interboard_msg_type (in, 3) and interboard_number (in, NW).
REQ-009 SHALL have outputs my_turn (1), transmit (1), ctrl_en (1), ctrl_msg_type (3) and ctrl_number (NW).
REQ-010 SHALL have outputs map (NW*N*N, cell k at bits [NW*k +: NW], row-major), circle (N*N) and line_count (clog2(2N+3)).
REQ-011 SHALL have output timeout_flag (1), a one-cycle pulse when an auto-guess fires.

Function
REQ-012 SHALL use the states IDLE, SEND_START, SEL, SEND_SEL_DONE, WAIT_P2_SEL, GUESS, CHECK_WIN, SEND_NUM, SEND_WIN, WAIT_P2_GUESS, UPDATE and FIN.
REQ-013 SHALL take these transitions: IDLE -start_game-> SEND_START -inter_ready-> SEL -board full-> SEND_SEL_DONE -inter_ready-> WAIT_P2_SEL -rx STATE_TURN-> GUESS.
REQ-014 SHALL take these transitions: GUESS -accepted guess-> CHECK_WIN, then -> SEND_WIN if won, else -> SEND_NUM -inter_ready-> WAIT_P2_GUESS.
REQ-015 SHALL take these transitions: WAIT_P2_GUESS -rx STATE_WIN-> FIN; WAIT_P2_GUESS -rx SEL_NUM-> UPDATE; UPDATE (1 cycle) -> SEND_WIN if won, else -> GUESS.
REQ-016 SHALL take these transitions: SEND_WIN -inter_ready-> FIN; FIN -start_game-> IDLE.
REQ-017 SHALL treat "rx X" as interboard_en=1 with interboard_msg_type=X; other messages in a given state SHALL be ignored.
REQ-018 SHALL, in SEL, accept enter_pulse only if 1<=cur_number<=N*N and the number is unused; it SHALL write the number to the next cell (index 0 upward) and update the reverse number-to-position table.
REQ-019 SHALL silently drop rejected SEL entries; the board is full after the N*N-th accept, and the transition SHALL occur on the next cycle.
REQ-020 SHALL, in GUESS, accept enter_pulse only if cur_number is in range and its cell is not yet circled; the circle bit SHALL set 1 cycle later and the state SHALL become CHECK_WIN.
REQ-021 SHALL, in UPDATE, circle the cell of the latched interboard_number; an out-of-range or already-circled value SHALL leave circle unchanged.
REQ-022 SHALL compute line_count combinationally from circle; "won" means line_count >= LINES_TO_WIN.
REQ-023 SHALL, when TIMEOUT>0, count cycles in GUESS without an accepted guess; at count==TIMEOUT it SHALL auto-guess the lowest-numbered uncircled value, pulse timeout_flag and proceed as for an accepted guess.
REQ-024 SHALL clear the timeout counter on entry to GUESS.
REQ-025 SHALL pulse ctrl_en for exactly 1 cycle on entry to each SEND_* state.
REQ-026 SHALL set ctrl_msg_type to STATE_TURN in SEND_START and SEND_SEL_DONE, SEL_NUM in SEND_NUM and STATE_WIN in SEND_WIN.
REQ-027 SHALL set ctrl_number to the guessed number in SEND_NUM and to 0 otherwise.
REQ-028 SHALL hold transmit=1 in all SEND_* states and 0 otherwise.
REQ-029 SHALL drive my_turn=1 in SEL, GUESS, CHECK_WIN and FIN.
REQ-030 SHALL give simultaneous enter_pulse and interboard_en no effect outside the states that consume them; in GUESS, enter_pulse SHALL win over the timeout in the same cycle.
REQ-031 SHALL clear map, circle and the used table on entry to IDLE.

Reset
REQ-032 SHALL, while rst_n=0 (asynchronous assert, synchronous deassert), force state=IDLE and map=0, circle=0, line_count=0, and my_turn, transmit, ctrl_en, ctrl_msg_type, ctrl_number and timeout_flag all to 0.
REQ-033 SHALL, on interboard_rst=1 at a clock edge, apply the same clear in any state, including mid-SEL and mid-send; the first legal action SHALL be start_game 1 cycle after release.

Verification
REQ-034 SHALL cover: N=5; start_game, inter_ready, enter 1..25 -> map cell k = k+1, one ctrl_en pulse with STATE_TURN, state WAIT_P2_SEL.
REQ-035 SHALL cover: in SEL, enter 0, 26 and a duplicate 7 -> all rejected, cell index unchanged.
REQ-036 SHALL cover: from GUESS, guess 1..5 (row 0) with LINES_TO_WIN=1 -> after the 5th guess, SEND_WIN, ctrl_msg_type=STATE_WIN, then FIN.
REQ-037 SHALL cover: in WAIT_P2_GUESS, rx SEL_NUM 13 -> circle[12]=1, state GUESS; rx SEL_NUM 13 again later -> no change.
REQ-038 SHALL cover: TIMEOUT=100, no input in GUESS -> at cycle 100, timeout_flag pulse, lowest uncircled number sent via SEL_NUM.
REQ-039 SHALL cover: rst_n asserted mid-SEND_NUM -> all outputs 0 within the same cycle, state IDLE.
